// File: rtl/psg_access_scheduler_if.sv
// Requester handshakes plus PSG bus-control pins shared by the access scheduler.
// master = requesters and PSG side; slave = the scheduler.
interface psg_access_scheduler_if;
    logic       req0_valid;
    logic       req0_write;
    logic [3:0] req0_addr;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic [7:0] req0_rdata;
    logic       req1_valid;
    logic [3:0] req1_addr;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic       psg_bc;
    logic       psg_bdir;
    logic [7:0] psg_dout;
    logic [7:0] psg_din;
    logic       busy;

    modport master (
        output req0_valid, req0_write, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output psg_din,
        input  req0_ready, req0_rdata, req1_ready,
        input  psg_bc, psg_bdir, psg_dout, busy
    );

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  psg_din,
        output req0_ready, req0_rdata, req1_ready,
        output psg_bc, psg_bdir, psg_dout, busy
    );
endinterface

// File: rtl/psg_access_scheduler.sv
// Arbitrates two PSG register requesters into BC/BDIR strobe sequences, skipping a re-latch of the cached address.
// Ready after 2*STROBE+GAP+1 cycles (STROBE+1 when cached); requests stall while busy, one idle cycle between accesses.
module psg_access_scheduler #(
    parameter int STROBE_CYCLES  = 2,
    parameter int GAP_CYCLES     = 1,
    parameter bit PORT0_PRIORITY = 1'b0
) (
    input logic                   clk,
    input logic                   reset,
    psg_access_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, GAP, WDATA, RDATA, DONE} state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    addr, addr_nxt;
    logic [7:0]    data, data_nxt;
    logic          write, write_nxt;
    logic          gnt, gnt_nxt;
    logic          last_gnt, last_gnt_nxt;
    logic [3:0]    last_addr, last_addr_nxt;
    logic          last_valid, last_valid_nxt;
    logic          pick1;
    logic          bc, bc_nxt;
    logic          bdir, bdir_nxt;
    logic [7:0]    dout, dout_nxt;
    logic          ready0, ready0_nxt;
    logic          ready1, ready1_nxt;
    logic [7:0]    rdata, rdata_nxt;
    logic          busy, busy_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            addr       <= '0;
            data       <= '0;
            write      <= 1'b0;
            gnt        <= 1'b0;
            last_gnt   <= 1'b1;
            last_addr  <= '0;
            last_valid <= 1'b0;
            bc         <= 1'b0;
            bdir       <= 1'b0;
            dout       <= '0;
            ready0     <= 1'b0;
            ready1     <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            addr       <= addr_nxt;
            data       <= data_nxt;
            write      <= write_nxt;
            gnt        <= gnt_nxt;
            last_gnt   <= last_gnt_nxt;
            last_addr  <= last_addr_nxt;
            last_valid <= last_valid_nxt;
            bc         <= bc_nxt;
            bdir       <= bdir_nxt;
            dout       <= dout_nxt;
            ready0     <= ready0_nxt;
            ready1     <= ready1_nxt;
            rdata      <= rdata_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 1'b1;
        addr_nxt       = addr;
        data_nxt       = data;
        write_nxt      = write;
        gnt_nxt        = gnt;
        last_gnt_nxt   = last_gnt;
        last_addr_nxt  = last_addr;
        last_valid_nxt = last_valid;
        rdata_nxt      = rdata;
        pick1          = 1'b0;

        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (bus.req0_valid || bus.req1_valid) begin
                    // Port 1 wins when alone, or on a round-robin tie after port 0 was served last
                    pick1 = bus.req1_valid &&
                            (!bus.req0_valid || (!PORT0_PRIORITY && !last_gnt));
                    gnt_nxt      = pick1;
                    last_gnt_nxt = pick1;
                    addr_nxt     = pick1 ? bus.req1_addr : bus.req0_addr;
                    data_nxt     = pick1 ? bus.req1_data : bus.req0_data;
                    write_nxt    = pick1 ? 1'b1 : bus.req0_write;
                    if (last_valid && (last_addr == addr_nxt))
                        state_nxt = write_nxt ? WDATA : RDATA;
                    else
                        state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (cnt == STROBE_LAST) begin
                    state_nxt      = GAP;
                    cnt_nxt        = '0;
                    last_addr_nxt  = addr;
                    last_valid_nxt = 1'b1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = write ? WDATA : RDATA;
                    cnt_nxt   = '0;
                end
            end
            WDATA: begin
                if (cnt == STROBE_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end
            end
            RDATA: begin
                if (cnt == STROBE_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    rdata_nxt = bus.psg_din;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered as a function of the state being entered
        bc_nxt   = (state_nxt == ADDR) || (state_nxt == RDATA);
        bdir_nxt = (state_nxt == ADDR) || (state_nxt == WDATA);
        dout_nxt = dout;
        if (state_nxt == ADDR)
            dout_nxt = {4'h0, addr_nxt};
        else if (state_nxt == WDATA)
            dout_nxt = data_nxt;
        ready0_nxt = (state_nxt == DONE) && !gnt_nxt;
        ready1_nxt = (state_nxt == DONE) && gnt_nxt;
        busy_nxt   = (state_nxt != IDLE);
    end

    assign bus.psg_bc     = bc;
    assign bus.psg_bdir   = bdir;
    assign bus.psg_dout   = dout;
    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.req0_rdata = rdata;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_psg_access_scheduler.sv
// Bench for psg_access_scheduler: round-robin and port-0-priority instances share one stimulus.
// Expected bus traces and grant order come from a cycle-count model of the access rules.
module tb_psg_access_scheduler;
    localparam int S = 2;
    localparam int G = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       r0_valid, r0_write, r1_valid;
    logic [3:0] r0_addr, r1_addr;
    logic [7:0] r0_data, r1_data, din;

    psg_access_scheduler_if ifa ();
    psg_access_scheduler_if ifb ();

    assign ifa.req0_valid = r0_valid;
    assign ifa.req0_write = r0_write;
    assign ifa.req0_addr  = r0_addr;
    assign ifa.req0_data  = r0_data;
    assign ifa.req1_valid = r1_valid;
    assign ifa.req1_addr  = r1_addr;
    assign ifa.req1_data  = r1_data;
    assign ifa.psg_din    = din;
    assign ifb.req0_valid = r0_valid;
    assign ifb.req0_write = r0_write;
    assign ifb.req0_addr  = r0_addr;
    assign ifb.req0_data  = r0_data;
    assign ifb.req1_valid = r1_valid;
    assign ifb.req1_addr  = r1_addr;
    assign ifb.req1_data  = r1_data;
    assign ifb.psg_din    = din;

    psg_access_scheduler #(.STROBE_CYCLES(S), .GAP_CYCLES(G), .PORT0_PRIORITY(1'b0)) dut_rr (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    psg_access_scheduler #(.STROBE_CYCLES(S), .GAP_CYCLES(G), .PORT0_PRIORITY(1'b1)) dut_pri (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         m_lv;
    logic [3:0] m_la;
    bit         m_last;
    logic [7:0] m_dout;
    logic [7:0] m_rdata;

    task automatic model_reset();
        m_lv = 1'b0; m_la = 4'h0; m_last = 1'b1; m_dout = 8'h00; m_rdata = 8'h00;
    endtask

    task automatic do_reset();
        reset = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_single(input bit port, input bit wr, input logic [3:0] addr,
                              input logic [7:0] data, input logic [7:0] rd_val);
        bit cached; int n_full; int n_act; logic [1:0] exp_bus; logic [1:0] got_bus;
        cached = m_lv && (m_la == addr);
        n_full = cached ? 0 : S + G;
        n_act  = n_full + S;
        if (port) begin
            r1_valid = 1'b1; r1_addr = addr; r1_data = data;
        end else begin
            r0_valid = 1'b1; r0_write = wr; r0_addr = addr; r0_data = data;
        end
        din = ~rd_val;
        m_last = port;
        for (int c = 0; c < n_act; c++) begin
            @(negedge clk);
            r0_addr = 4'($urandom); r0_data = 8'($urandom); r0_write = 1'($urandom);
            r1_addr = 4'($urandom); r1_data = 8'($urandom);
            if (!cached && c < S) begin
                exp_bus = 2'b11; m_dout = {4'h0, addr};
            end else if (c < n_full) begin
                exp_bus = 2'b00;
            end else begin
                exp_bus = wr ? 2'b01 : 2'b10;
                if (wr) m_dout = data;
            end
            got_bus = {ifa.psg_bc, ifa.psg_bdir};
            total++;
            if (got_bus !== exp_bus) begin
                bad++;
                $display("FAIL bus_phase[%0d] port=%0d reg=%h: got bc/bdir=%b expected %b", c, port, addr, got_bus, exp_bus);
            end
            total++;
            if (ifa.psg_dout !== m_dout) begin
                bad++;
                $display("FAIL dout[%0d] port=%0d reg=%h: got %h expected %h", c, port, addr, ifa.psg_dout, m_dout);
            end
            total++;
            if ({ifa.busy, ifa.req0_ready, ifa.req1_ready} !== 3'b100) begin
                bad++;
                $display("FAIL active_flags[%0d]: got busy/rdy0/rdy1=%b expected 100", c, {ifa.busy, ifa.req0_ready, ifa.req1_ready});
            end
            din = (!wr && c == n_act - 1) ? rd_val : ~rd_val;
        end
        @(negedge clk);
        if (!wr) m_rdata = rd_val;
        din = ~rd_val;
        total++;
        if ({ifa.psg_bc, ifa.psg_bdir, ifa.busy, ifa.req0_ready, ifa.req1_ready} !== {3'b001, ~port, port}) begin
            bad++;
            $display("FAIL done_flags port=%0d: got bc/bdir/busy/rdy0/rdy1=%b expected %b", port,
                     {ifa.psg_bc, ifa.psg_bdir, ifa.busy, ifa.req0_ready, ifa.req1_ready}, {3'b001, ~port, port});
        end
        total++;
        if (ifa.req0_rdata !== m_rdata || ifa.psg_dout !== m_dout) begin
            bad++;
            $display("FAIL done_data: got rdata=%h dout=%h expected rdata=%h dout=%h", ifa.req0_rdata, ifa.psg_dout, m_rdata, m_dout);
        end
        if (port) r1_valid = 1'b0; else r0_valid = 1'b0;
        if (!cached) begin m_lv = 1'b1; m_la = addr; end
        @(negedge clk);
        total++;
        if ({ifa.busy, ifa.req0_ready, ifa.req1_ready} !== 3'b000 || ifa.req0_rdata !== m_rdata || ifa.psg_dout !== m_dout) begin
            bad++;
            $display("FAIL idle_after: got busy/rdy=%b rdata=%h dout=%h expected 000 %h %h",
                     {ifa.busy, ifa.req0_ready, ifa.req1_ready}, ifa.req0_rdata, ifa.psg_dout, m_rdata, m_dout);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; r0_valid = 1'b0; r1_valid = 1'b0; r0_write = 1'b0;
        r0_addr = 4'h0; r0_data = 8'h00; r1_addr = 4'h0; r1_data = 8'h00; din = 8'h00;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({ifa.psg_bc, ifa.psg_bdir, ifa.busy, ifa.req0_ready, ifa.req1_ready, ifa.psg_dout, ifa.req0_rdata} !== 21'd0 ||
            {ifb.psg_bc, ifb.psg_bdir, ifb.busy, ifb.req0_ready, ifb.req1_ready, ifb.psg_dout, ifb.req0_rdata} !== 21'd0) begin
            bad++;
            $display("FAIL reset_values: got rr=%h pri=%h expected 0",
                     {ifa.psg_bc, ifa.psg_bdir, ifa.busy, ifa.req0_ready, ifa.req1_ready, ifa.psg_dout, ifa.req0_rdata},
                     {ifb.psg_bc, ifb.psg_bdir, ifb.busy, ifb.req0_ready, ifb.req1_ready, ifb.psg_dout, ifb.req0_rdata});
        end
        reset = 1'b0;
        model_reset();
        r1_valid = 1'b1; r1_addr = 4'h7; r1_data = 8'h55;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (ifa.req1_ready !== 1'b0) begin
                bad++;
                $display("FAIL abort_no_ready[%0d]: got %b expected 0", c, ifa.req1_ready);
            end
        end
        total++;
        if ({ifa.psg_bc, ifa.psg_bdir} !== 2'b01) begin
            bad++;
            $display("FAIL abort_in_wdata: got bc/bdir=%b expected 01", {ifa.psg_bc, ifa.psg_bdir});
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({ifa.psg_bc, ifa.psg_bdir, ifa.busy, ifa.req1_ready, ifa.psg_dout} !== 12'd0) begin
            bad++;
            $display("FAIL mid_reset: got bc/bdir/busy/rdy1/dout=%h expected 0",
                     {ifa.psg_bc, ifa.psg_bdir, ifa.busy, ifa.req1_ready, ifa.psg_dout});
        end
        reset = 1'b0;
        r1_valid = 1'b0;
        model_reset();
    endtask

    task automatic test_single_write();
        run_single(1'b1, 1'b1, 4'h7, 8'h38, 8'h00);
    endtask

    task automatic test_cached_write();
        run_single(1'b1, 1'b1, 4'h7, 8'h3F, 8'h00);
    endtask

    task automatic test_read();
        run_single(1'b0, 1'b0, 4'hE, 8'($urandom), 8'hA5);
    endtask

    task automatic test_addr_switch();
        run_single(1'b0, 1'b1, 4'h8, 8'($urandom), 8'h00);
        run_single(1'b1, 1'b1, 4'h9, 8'($urandom), 8'h00);
        run_single(1'b0, 1'b1, 4'h8, 8'($urandom), 8'h00);
    endtask

    task automatic test_random();
        bit port; bit wr;
        for (int i = 0; i < 24; i++) begin
            port = 1'($urandom);
            wr   = port ? 1'b1 : 1'($urandom);
            run_single(port, wr, 4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end
    endtask

    task automatic test_contention(input bit prio);
        logic [3:0] a [2];
        int served; int gap; int exp_gap;
        bit exp_port; bit got0; bit got1; bit cached;
        do_reset();
        a[0] = 4'($urandom_range(0, 1));
        a[1] = 4'($urandom_range(0, 1));
        r0_valid = 1'b1; r0_write = 1'b1; r0_addr = a[0]; r0_data = 8'($urandom);
        r1_valid = 1'b1; r1_addr = a[1]; r1_data = 8'($urandom);
        exp_port = prio ? 1'b0 : ~m_last;
        cached   = m_lv && (m_la == a[exp_port]);
        exp_gap  = (cached ? S : 2 * S + G) + 1;
        served = 0; gap = 0;
        for (int cyc = 0; cyc < 300 && served < 4; cyc++) begin
            @(negedge clk);
            gap++;
            got0 = prio ? ifb.req0_ready : ifa.req0_ready;
            got1 = prio ? ifb.req1_ready : ifa.req1_ready;
            if (got0 || got1) begin
                total++;
                if ((got0 && got1) || got1 !== exp_port) begin
                    bad++;
                    $display("FAIL grant_order prio=%0d #%0d: got rdy0/rdy1=%b%b expected port %0d", prio, served, got0, got1, exp_port);
                end
                total++;
                if (gap != exp_gap) begin
                    bad++;
                    $display("FAIL grant_spacing prio=%0d #%0d: got %0d cycles expected %0d", prio, served, gap, exp_gap);
                end
                if (!cached) begin m_lv = 1'b1; m_la = a[exp_port]; end
                m_last = exp_port;
                a[exp_port] = 4'($urandom_range(0, 1));
                if (exp_port) begin r1_addr = a[1]; r1_data = 8'($urandom); end
                else begin r0_addr = a[0]; r0_data = 8'($urandom); end
                served++;
                gap = 0;
                exp_port = prio ? 1'b0 : ~m_last;
                cached   = m_lv && (m_la == a[exp_port]);
                exp_gap  = (cached ? S : 2 * S + G) + 2;
            end
        end
        total++;
        if (served != 4) begin
            bad++;
            $display("FAIL contention_timeout prio=%0d: got %0d grants expected 4", prio, served);
        end
        do_reset();
    endtask

    task automatic test_valid_drop();
        bit idle_seen;
        r0_valid = 1'b1; r0_write = 1'($urandom); r0_addr = 4'($urandom); r0_data = 8'($urandom);
        @(negedge clk);
        r0_valid = 1'b0;
        idle_seen = 1'b0;
        for (int c = 0; c < 20 && !idle_seen; c++) begin
            @(negedge clk);
            if (ifa.busy === 1'b0) idle_seen = 1'b1;
        end
        total++;
        if (!idle_seen) begin
            bad++;
            $display("FAIL valid_drop_recover: got busy=%b expected return to idle", ifa.busy);
        end
        do_reset();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_cached_write();
        test_read();
        test_addr_switch();
        test_random();
        test_valid_drop();
        test_contention(1'b0);
        test_contention(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
